// File: rtl/key_event_fifo_if.sv
// Key event stream between key_event_fifo (master) and its consumer (slave).
//   ev_valid : head entry of the event FIFO is valid
//   ev_data  : head event {press, 3'b000, key index}
//   ev_ready : consumer accepts the head event this cycle
interface key_event_fifo_if;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_ready;

  modport master (
    output ev_valid,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/key_event_fifo.sv
// Debounces active-low push-buttons, converts each accepted level change into a
// press/release event and queues the events in a first-word-fall-through FIFO.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   keys_n     : raw key pins, 0 = pressed, asynchronous to clk
//   key_state  : debounced key levels, 1 = pressed
//   ev         : event stream (valid/data/ready), master side
//   fifo_count : number of queued events
//   overflow   : sticky flag, an event was dropped because the FIFO was full
//   ovf_clear  : clears overflow (a simultaneous drop wins)
module key_event_fifo #(
  parameter int unsigned NUM_KEYS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_KEYS-1:0]          keys_n,
  output logic [NUM_KEYS-1:0]          key_state,
  key_event_fifo_if.master             ev,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         ovf_clear
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned EV_W  = 8;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer (raw polarity, resets to released)
  logic [NUM_KEYS-1:0] r_meta_n;
  logic [NUM_KEYS-1:0] r_sync_n;
  logic [NUM_KEYS-1:0] w_sync;

  // Debounce state
  logic [DB_W-1:0]     r_db_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_stable;
  logic [NUM_KEYS-1:0] w_flip;

  // Event arbitration
  logic [NUM_KEYS-1:0] r_pending;
  logic [NUM_KEYS-1:0] w_grant;
  logic                w_sel_vld;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_sel_lvl;
  logic [EV_W-1:0]     w_event;

  // Event FIFO
  logic [EV_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;
  logic                w_pop;
  logic                w_accept;
  logic                w_push;
  logic                w_drop;

  // Two-flop synchronizer on the raw pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta_n <= '1;
      r_sync_n <= '1;
    end else begin
      r_meta_n <= keys_n;
      r_sync_n <= r_meta_n;
    end
  end

  assign w_sync = ~r_sync_n;

  // A key's level is accepted on the last cycle of an uninterrupted mismatch run
  always_comb begin
    w_flip = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_flip[k] = (w_sync[k] != r_stable[k]) && (r_db_cnt[k] == DB_LAST);
    end
  end

  // Debounce counters and stable levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_db_cnt[k] <= '0;
      end
      r_stable <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_sync[k] == r_stable[k]) begin
          r_db_cnt[k] <= '0;
        end else if (w_flip[k]) begin
          r_db_cnt[k] <= '0;
          r_stable[k] <= w_sync[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Lowest-index pending key wins; one event per cycle
  always_comb begin
    w_grant   = '0;
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_sel_lvl = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (r_pending[k] && !w_sel_vld) begin
        w_sel_vld  = 1'b1;
        w_sel_idx  = IDX_W'(k);
        w_sel_lvl  = r_stable[k];
        w_grant[k] = 1'b1;
      end
    end
  end

  assign w_event = {w_sel_lvl, 3'b000, w_sel_idx};

  // Pending flags: a flip cannot coincide with a grant of the same key because
  // the debounce window is longer than the worst-case arbitration wait
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_flip;
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_pop    = (r_count != '0) && ev.ev_ready;
  assign w_accept = (r_count < CW'(FIFO_DEPTH)) || w_pop;
  assign w_push   = w_sel_vld && w_accept;
  assign w_drop   = w_sel_vld && !w_accept;

  // FIFO storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_event;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a drop outranks a clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign key_state   = r_stable;
  assign ev.ev_valid = (r_count != '0);
  assign ev.ev_data  = r_mem[r_rd_ptr];
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: two instances (FIFO depth 8 and 2) share keys and
// reset; each has its own ready/clear and its own reference state.
module tb_key_event_fifo;

  localparam int DB = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] keys_n;
  logic [1:0] rdy;
  logic [1:0] clr;

  logic [2:0] ks0, ks1;
  logic [3:0] fc0;
  logic [1:0] fc1;
  logic       ovf0, ovf1;

  int checks;
  int failures;

  key_event_fifo_if if0 ();
  key_event_fifo_if if1 ();

  assign if0.ev_ready = rdy[0];
  assign if1.ev_ready = rdy[1];

  key_event_fifo #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .keys_n(keys_n), .key_state(ks0),
    .ev(if0), .fifo_count(fc0), .overflow(ovf0), .ovf_clear(clr[0])
  );

  key_event_fifo #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .keys_n(keys_n), .key_state(ks1),
    .ev(if1), .fifo_count(fc1), .overflow(ovf1), .ovf_clear(clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: pressed-polarity samples delayed two edges, the length of
  // the current disagreement run, a set of keys awaiting an event slot, and the
  // queued events as a shift list (index 0 = head).
  int         m_depth [2];
  logic [2:0] m_stable[2];
  logic [2:0] m_pend  [2];
  logic [2:0] m_dly1  [2];
  logic [2:0] m_dly2  [2];
  int         m_run   [2][3];
  logic [7:0] m_buf   [2][8];
  int         m_cnt   [2];
  logic       m_ovf   [2];

  task automatic model_reset(int u);
    m_stable[u] = '0;
    m_pend[u]   = '0;
    m_dly1[u]   = '0;
    m_dly2[u]   = '0;
    for (int k = 0; k < 3; k++) m_run[u][k] = 0;
    for (int i = 0; i < 8; i++) m_buf[u][i] = '0;
    m_cnt[u] = 0;
    m_ovf[u] = 1'b0;
  endtask

  // Advance the reference across one rising edge using the inputs now applied
  task automatic model_step();
    int         sel;
    bit         pop;
    bit         acc;
    logic [7:0] evb;
    for (int u = 0; u < 2; u++) begin
      if (!reset_n) begin
        model_reset(u);
      end else begin
        sel = -1;
        for (int k = 0; k < 3; k++) if (m_pend[u][k] && sel < 0) sel = k;
        pop = (m_cnt[u] > 0) && rdy[u];
        acc = (m_cnt[u] < m_depth[u]) || pop;
        if (pop) begin
          for (int i = 0; i < 7; i++) m_buf[u][i] = m_buf[u][i+1];
          m_cnt[u]--;
        end
        if (sel >= 0) begin
          evb = {m_stable[u][sel], 3'b000, 4'(sel)};
          m_pend[u][sel] = 1'b0;
          if (acc) begin
            m_buf[u][m_cnt[u]] = evb;
            m_cnt[u]++;
          end else begin
            m_ovf[u] = 1'b1;
          end
        end
        if (clr[u] && !(sel >= 0 && !acc)) m_ovf[u] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (m_dly2[u][k] == m_stable[u][k]) begin
            m_run[u][k] = 0;
          end else begin
            m_run[u][k]++;
            if (m_run[u][k] == DB) begin
              m_stable[u][k] = m_dly2[u][k];
              m_run[u][k]    = 0;
              m_pend[u][k]   = 1'b1;
            end
          end
        end
        m_dly2[u] = m_dly1[u];
        m_dly1[u] = ~keys_n;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_unit(int u, logic [31:0] ks, logic [31:0] vld, logic [31:0] dat,
                            logic [31:0] cnt, logic [31:0] ovf);
    chk($sformatf("u%0d_key_state", u), ks, 32'(m_stable[u]));
    chk($sformatf("u%0d_ev_valid", u), vld, 32'(m_cnt[u] != 0));
    chk($sformatf("u%0d_fifo_count", u), cnt, 32'(m_cnt[u]));
    chk($sformatf("u%0d_overflow", u), ovf, 32'(m_ovf[u]));
    if (m_cnt[u] != 0) chk($sformatf("u%0d_ev_data", u), dat, 32'(m_buf[u][0]));
  endtask

  task automatic check_all();
    check_unit(0, 32'(ks0), 32'(if0.ev_valid), 32'(if0.ev_data), 32'(fc0), 32'(ovf0));
    check_unit(1, 32'(ks1), 32'(if1.ev_valid), 32'(if1.ev_data), 32'(fc1), 32'(ovf1));
  endtask

  // One clock: inputs are applied at the falling edge before calling
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain(int n);
    rdy = 2'b11;
    repeat (n) cyc();
    rdy = 2'b00;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ks0"}, 32'(ks0), 32'h0);
    chk({tag, "_vld0"}, 32'(if0.ev_valid), 32'h0);
    chk({tag, "_data0"}, 32'(if0.ev_data), 32'h0);
    chk({tag, "_cnt0"}, 32'(fc0), 32'h0);
    chk({tag, "_ovf0"}, 32'(ovf0), 32'h0);
    chk({tag, "_ks1"}, 32'(ks1), 32'h0);
    chk({tag, "_vld1"}, 32'(if1.ev_valid), 32'h0);
    chk({tag, "_data1"}, 32'(if1.ev_data), 32'h0);
    chk({tag, "_cnt1"}, 32'(fc1), 32'h0);
    chk({tag, "_ovf1"}, 32'(ovf1), 32'h0);
  endtask

  int hold[3];

  initial begin
    checks     = 0;
    failures   = 0;
    m_depth[0] = 8;
    m_depth[1] = 2;
    reset_n    = 1'b0;
    keys_n     = 3'b111;
    rdy        = 2'b00;
    clr        = 2'b00;
    model_reset(0);
    model_reset(1);

    // Reset state
    repeat (3) cyc();
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) cyc();

    // Single press on key 1: level after E5, event after E6
    keys_n[1] = 1'b0;
    repeat (5) cyc();
    chk("t1_state_E4", 32'(ks0), 32'h0);
    cyc();
    chk("t1_state_E5", 32'(ks0), 32'h2);
    chk("t1_valid_E5", 32'(if0.ev_valid), 32'h0);
    cyc();
    chk("t1_valid_E6", 32'(if0.ev_valid), 32'h1);
    chk("t1_data_E6", 32'(if0.ev_data), 32'h81);
    chk("t1_data_E6_u1", 32'(if1.ev_data), 32'h81);
    rdy = 2'b11;
    cyc();
    rdy = 2'b00;
    chk("t1_valid_popped", 32'(if0.ev_valid), 32'h0);
    chk("t1_count_popped", 32'(fc0), 32'h0);
    keys_n[1] = 1'b1;
    repeat (7) cyc();
    chk("t1_release_data", 32'(if0.ev_data), 32'h01);
    drain(2);

    // Glitch of three cycles on key 0 is filtered out
    keys_n[0] = 1'b0;
    repeat (3) cyc();
    keys_n[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_glitch_state", 32'(ks0), 32'h0);
      chk("t2_glitch_count", 32'(fc0), 32'h0);
    end

    // Three keys together: consecutive pushes, lowest index first
    keys_n = 3'b000;
    repeat (6) cyc();
    chk("t3_count_E5", 32'(fc0), 32'h0);
    cyc();
    chk("t3_count_1", 32'(fc0), 32'h1);
    cyc();
    chk("t3_count_2", 32'(fc0), 32'h2);
    cyc();
    chk("t3_count_3", 32'(fc0), 32'h3);
    chk("t3_small_count", 32'(fc1), 32'h2);
    chk("t3_small_ovf", 32'(ovf1), 32'h1);
    chk("t3_pop0", 32'(if0.ev_data), 32'h80);
    chk("t3_small_pop0", 32'(if1.ev_data), 32'h80);
    rdy = 2'b11;
    cyc();
    chk("t3_pop1", 32'(if0.ev_data), 32'h81);
    chk("t3_small_pop1", 32'(if1.ev_data), 32'h81);
    cyc();
    chk("t3_pop2", 32'(if0.ev_data), 32'h82);
    chk("t3_small_empty", 32'(fc1), 32'h0);
    cyc();
    rdy = 2'b00;
    chk("t3_empty", 32'(if0.ev_valid), 32'h0);
    clr = 2'b10;
    cyc();
    clr = 2'b00;
    chk("t3_ovf_cleared", 32'(ovf1), 32'h0);

    // Releases: ready on the small FIFO only during the third push
    keys_n = 3'b111;
    repeat (8) cyc();
    chk("t4_small_full", 32'(fc1), 32'h2);
    rdy = 2'b10;
    cyc();
    rdy = 2'b00;
    chk("t4_small_count", 32'(fc1), 32'h2);
    chk("t4_small_no_ovf", 32'(ovf1), 32'h0);
    chk("t4_small_head", 32'(if1.ev_data), 32'h01);
    chk("t4_big_count", 32'(fc0), 32'h3);
    drain(6);

    // Reset mid-debounce with two events queued
    keys_n[0] = 1'b0;
    repeat (7) cyc();
    keys_n[0] = 1'b1;
    repeat (7) cyc();
    chk("t5_queued", 32'(fc0), 32'h2);
    keys_n[2] = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_zero("t5_async");
    @(negedge clk);
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (6) cyc();
    chk("t5_no_event_yet", 32'(if0.ev_valid), 32'h0);
    cyc();
    chk("t5_event_valid", 32'(if0.ev_valid), 32'h1);
    chk("t5_event_data", 32'(if0.ev_data), 32'h82);
    repeat (8) cyc();
    chk("t5_single_event", 32'(fc0), 32'h1);
    keys_n = 3'b111;
    drain(12);

    // Random key activity, handshakes and clears against the reference
    for (int k = 0; k < 3; k++) hold[k] = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          keys_n[k] = ~keys_n[k];
          hold[k]   = $urandom_range(1, 12);
        end else begin
          hold[k]--;
        end
      end
      rdy[0] = ($urandom_range(0, 3) == 0);
      rdy[1] = ($urandom_range(0, 3) == 0);
      clr[0] = ($urandom_range(0, 15) == 0);
      clr[1] = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
